word_serializer_pre: RTL and testbench

//  Parallel-to-serial front end for the serial pattern detectors.

---
 rtl/word_serializer_pre_if.sv | 52 +++++
 rtl/word_serializer_pre.sv | 140 ++++++++++++++
 tb/tb_word_serializer_pre.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pre_if.sv
// ----------------------------------------------------------------------------
// word_serializer_pre_if
//
// Purpose:
//   Groups the parallel word handshake and the serial output signals of
//   word_serializer_pre into one bundle. The producer of words uses the
//   master view. The serializer itself uses the slave view.
//
// Signals:
//   din        WIDTH  parallel word                   (master -> slave)
//   din_valid  1      din is valid                    (master -> slave)
//   din_ready  1      serializer can accept din       (slave -> master)
//   j          1      registered serial bit stream    (slave -> master)
//   j_valid    1      j carries a data bit            (slave -> master)
//   word_done  1      j carries the last bit of word  (slave -> master)
//   busy       1      shift word active or word held  (slave -> master)
// ----------------------------------------------------------------------------
interface word_serializer_pre_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             j;
    logic             j_valid;
    logic             word_done;
    logic             busy;

    // Producer side: drives the word and its valid, watches everything else.
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  j,
        input  j_valid,
        input  word_done,
        input  busy
    );

    // Serializer side: consumes the word, drives the serial stream and status.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output j,
        output j_valid,
        output word_done,
        output busy
    );

endinterface

// File: rtl/word_serializer_pre.sv
// ----------------------------------------------------------------------------
// word_serializer_pre
//
// Purpose:
//   Parallel-to-serial front end for the serial pattern detectors. WIDTH-bit
//   words arrive over a valid/ready handshake and leave one bit per clock on
//   the registered output j. A one-word pending buffer lets back-to-back
//   words stream out with no idle cycle between them.
//
// Parameters:
//   WIDTH       bits per word (2..32)
//   MSB_FIRST   1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_LEVEL  level driven on j while no word is being shifted
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   slave view of word_serializer_pre_if
//         (din, din_valid in; din_ready, j, j_valid, word_done, busy out)
// ----------------------------------------------------------------------------
module word_serializer_pre #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    word_serializer_pre_if.slave  bus
);

    localparam int                 CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   PRELAST_CNT = CNT_W'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shiftReg_q;
    logic [CNT_W-1:0]   bitCnt_q;
    logic [WIDTH-1:0]   pendWord_q;
    logic               pendFull_q;
    logic               jBit_q;
    logic               jValid_q;
    logic               wordDone_q;

    logic               accept;
    logic               lastBit;
    logic               loadEn_d;
    logic [WIDTH-1:0]   loadWord_d;

    // The bit that goes onto j first when a word is loaded or shifted.
    function automatic logic headBit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // What remains in the shift register once the head bit has gone to j.
    function automatic logic [WIDTH-1:0] tailBits(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // din_ready depends only on the pending flag, so din_valid never reaches
    // din_ready combinationally.
    assign accept  = bus.din_valid & ~pendFull_q;
    assign lastBit = (state_q == SHIFT) && (bitCnt_q == LAST_CNT);

    // Decide whether the shift register reloads at this edge and from where.
    // A held pending word always wins; it blocks din_ready, so it can never
    // collide with a fresh accept. In IDLE the pending buffer is always empty.
    always_comb begin
        loadEn_d   = 1'b0;
        loadWord_d = bus.din;
        if (state_q == IDLE) begin
            loadEn_d = accept;
        end else if (lastBit) begin
            if (pendFull_q) begin
                loadEn_d   = 1'b1;
                loadWord_d = pendWord_q;
            end else begin
                loadEn_d = accept;
            end
        end
    end

    // Main sequencer: state, shift register, bit counter, pending buffer and
    // the registered outputs all move together on one edge. The head bit of a
    // newly loaded word goes straight into jBit_q so it appears on j in the
    // cycle right after the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            pendWord_q <= '0;
            pendFull_q <= 1'b0;
            jBit_q     <= IDLE_LEVEL;
            jValid_q   <= 1'b0;
            wordDone_q <= 1'b0;
        end else begin
            if (loadEn_d) begin
                state_q    <= SHIFT;
                shiftReg_q <= tailBits(loadWord_d);
                jBit_q     <= headBit(loadWord_d);
                jValid_q   <= 1'b1;
                bitCnt_q   <= '0;
                wordDone_q <= 1'b0;
                if (pendFull_q) begin
                    pendFull_q <= 1'b0;
                end
            end else if (lastBit) begin
                state_q    <= IDLE;
                jBit_q     <= IDLE_LEVEL;
                jValid_q   <= 1'b0;
                bitCnt_q   <= '0;
                wordDone_q <= 1'b0;
            end else if (state_q == SHIFT) begin
                shiftReg_q <= tailBits(shiftReg_q);
                jBit_q     <= headBit(shiftReg_q);
                bitCnt_q   <= bitCnt_q + CNT_W'(1);
                // Flag the last bit in the same cycle it sits on j.
                wordDone_q <= (bitCnt_q == PRELAST_CNT);
            end

            // A word accepted mid-word has nowhere to go but the pending slot.
            if (accept && !loadEn_d) begin
                pendWord_q <= bus.din;
                pendFull_q <= 1'b1;
            end
        end
    end

    assign bus.din_ready = ~pendFull_q;
    assign bus.j         = jBit_q;
    assign bus.j_valid   = jValid_q;
    assign bus.word_done = wordDone_q;
    assign bus.busy      = (state_q == SHIFT) | pendFull_q;

endmodule

// File: tb/tb_word_serializer_pre.sv
// ----------------------------------------------------------------------------
// tb_word_serializer_pre
//
// Purpose:
//   Directed self-checking bench for word_serializer_pre. dutA is the default
//   MSB-first configuration, dutB is LSB-first. Both share clock and reset.
//   Outputs are sampled 1 time unit after each rising edge, and inputs are
//   changed at that same point, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_word_serializer_pre;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    word_serializer_pre_if #(.WIDTH(8)) busA ();
    word_serializer_pre_if #(.WIDTH(8)) busB ();

    word_serializer_pre #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    word_serializer_pre #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the word/valid pair of one DUT (sel=0: dutA, sel=1: dutB).
    task automatic applyStimulus(input bit sel, input logic [7:0] word, input logic valid);
        if (sel) begin
            busB.din       = word;
            busB.din_valid = valid;
        end else begin
            busA.din       = word;
            busA.din_valid = valid;
        end
    endtask

    // The one place where observed values meet expected ones.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output of one DUT against the expected cycle values.
    task automatic checkCycle(input string tag, input bit sel, input logic expJ, input logic expValid,
                              input logic expDone, input logic expReady, input logic expBusy);
        logic oJ, oValid, oDone, oReady, oBusy;
        oJ     = sel ? busB.j         : busA.j;
        oValid = sel ? busB.j_valid   : busA.j_valid;
        oDone  = sel ? busB.word_done : busA.word_done;
        oReady = sel ? busB.din_ready : busA.din_ready;
        oBusy  = sel ? busB.busy      : busA.busy;
        checkOutput($sformatf("%s.j", tag),         {31'b0, oJ},     {31'b0, expJ});
        checkOutput($sformatf("%s.j_valid", tag),   {31'b0, oValid}, {31'b0, expValid});
        checkOutput($sformatf("%s.word_done", tag), {31'b0, oDone},  {31'b0, expDone});
        checkOutput($sformatf("%s.din_ready", tag), {31'b0, oReady}, {31'b0, expReady});
        checkOutput($sformatf("%s.busy", tag),      {31'b0, oBusy},  {31'b0, expBusy});
    endtask

    // Directed test sequence with hand-computed expected streams.
    initial begin
        logic [7:0]  expBits;
        logic [15:0] expStream;

        $display("[TB] start");

        // Reset held for two edges while a word is offered: nothing accepted.
        rst = 1'b1;
        applyStimulus(1'b0, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkCycle($sformatf("t1.rstA%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkCycle($sformatf("t1.rstB%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkCycle("t1.post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Single MSB-first word 00010110.
        expBits = 8'b0001_0110;
        applyStimulus(1'b0, 8'b0001_0110, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) applyStimulus(1'b0, 8'h00, 1'b0);
            checkCycle($sformatf("t2.bit%0d", i), 1'b0, expBits[7-i], 1'b1, (i == 7), 1'b1, 1'b1);
        end
        tick();
        checkCycle("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // B5 then 5A back to back through the pending slot; din wiggles while
        // din_ready is low and must be ignored.
        expStream = 16'b1011_0101_0101_1010;
        applyStimulus(1'b0, 8'hB5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkCycle($sformatf("t3.bit%0d", i), 1'b0, expStream[15-i], 1'b1,
                       (i == 7) || (i == 15), (i == 0) || (i >= 8), 1'b1);
            if (i == 0) applyStimulus(1'b0, 8'h5A, 1'b1);
            if (i == 1) applyStimulus(1'b0, 8'hFF, 1'b1);
            if (i == 6) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        tick();
        checkCycle("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // C3 then 3C offered exactly on the last-bit edge: loads directly,
        // din_ready never drops.
        expStream = 16'b1100_0011_0011_1100;
        applyStimulus(1'b0, 8'hC3, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkCycle($sformatf("t7.bit%0d", i), 1'b0, expStream[15-i], 1'b1,
                       (i == 7) || (i == 15), 1'b1, 1'b1);
            if (i == 0) applyStimulus(1'b0, 8'h00, 1'b0);
            if (i == 7) applyStimulus(1'b0, 8'h3C, 1'b1);
            if (i == 8) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        tick();
        checkCycle("t7.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset after three bits of FF with 0F pending; 0F must never show up.
        applyStimulus(1'b0, 8'hFF, 1'b1);
        tick();
        checkCycle("t4.bit0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h0F, 1'b1);
        tick();
        checkCycle("t4.bit1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkCycle("t4.bit2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 8'hAA, 1'b1);
        tick();
        checkCycle("t4.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkCycle($sformatf("t4.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // LSB-first word 01 on dutB: a one, then seven zeros.
        expBits = 8'b1000_0000;
        applyStimulus(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) applyStimulus(1'b1, 8'h00, 1'b0);
            checkCycle($sformatf("t5.bit%0d", i), 1'b1, expBits[7-i], 1'b1, (i == 7), 1'b1, 1'b1);
        end
        tick();
        checkCycle("t5.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // AA, four idle cycles, then 55 starting right after its accept edge.
        expBits = 8'b1010_1010;
        applyStimulus(1'b0, 8'hAA, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) applyStimulus(1'b0, 8'h00, 1'b0);
            checkCycle($sformatf("t6.aa%0d", i), 1'b0, expBits[7-i], 1'b1, (i == 7), 1'b1, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCycle($sformatf("t6.gap%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        expBits = 8'b0101_0101;
        applyStimulus(1'b0, 8'h55, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) applyStimulus(1'b0, 8'h00, 1'b0);
            checkCycle($sformatf("t6.x55_%0d", i), 1'b0, expBits[7-i], 1'b1, (i == 7), 1'b1, 1'b1);
        end
        tick();
        checkCycle("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
